activation_unpacker: RTL and testbench
======================================

// Module: activation_unpacker
// PURPOSE
//  Reader-side counterpart of the output scaling stage. Takes 32-bit words of packed low-bit
//  activations (cfg_output_bits per element, LSB-first) from activation memory. Unpacks one
//  element per cycle, sign- or zero-extends it and subtracts the zero-point offset.
//  Feeds the resulting signed values to the next layer's array input.
//  Sits between the activation buffer read port and the array input driver.
// PARAMETERS
//  wordWidth      32  packed input word width
//  maxOutputWidth 8   largest element width (same as the output scaler)
//  outWidth       10  signed result width = maxOutputWidth+2, holds -383..255
//  countBits      16  width of the element-count register
// PORTS
//  clk            in   1               clock, all logic on rising edge
//  nrst           in   1               synchronous, active-high reset
//  start          in   1               one-cycle pulse that latches cfg_* and begins a transfer
//  cfg_output_bits in  4               element width; legal values 1,2,4,8
//  cfg_unsigned   in   1               1 = zero-extend elements, 0 = sign-extend
//  cfg_offset     in   maxOutputWidth  zero-point, unsigned, subtracted from every element
//  cfg_num_elems  in   countBits       total elements in this transfer
//  in_word        in   wordWidth       packed word
//  in_valid       in   1               in_word is valid
//  in_ready       out  1               unpacker accepts in_word this cycle
//  out_data       out  outWidth        signed unpacked value
//  out_valid      out  1               out_data is valid
//  out_ready      in   1               consumer accepts out_data
//  out_last       out  1               out_data is the final element of the transfer
//  busy           out  1               a transfer is in progress
//  done           out  1               one-cycle pulse after the final element handshake
// BEHAVIOUR
//  - Reset: state=IDLE; in_ready, out_valid, out_last, busy and done = 0; out_data = 0; buffer cleared.
//  - Reset has priority over every other event, including mid-transfer; partial data is dropped.
//  - FSM states are IDLE, FETCH, EMIT and DONE:
//      IDLE --start--> FETCH, or DONE if cfg_num_elems==0.
//      FETCH --in_valid&&in_ready--> EMIT.
//      EMIT --handshake on last element of word, transfer not finished--> FETCH.
//      EMIT --handshake on transfer's final element--> DONE.
//      DONE --> IDLE unconditionally; done=1 only in DONE.
//  - start is ignored unless the FSM is in IDLE. cfg_* are sampled only at start.
//  - Illegal cfg_output_bits values are treated as 8.
//  - Elements per word: epw = wordWidth / bits, giving 32, 16, 8 or 4.
//  - Word acceptance:
//      in_ready = (FETCH) OR (EMIT && out_ready && last element of word && elements remain).
//      This gives back-to-back words with no bubble. in_ready is 0 in IDLE and DONE.
//  - Latency: a word accepted on cycle N gives out_valid=1 on cycle N+1.
//  - out_data is registered from the buffer. A handshake shifts the buffer right by bits.
//  - While out_valid && !out_ready, out_data and out_last hold stable.
//  - Arithmetic:
//      e = buf[bits-1:0], zero- or sign-extended to outWidth.
//      out_data = e - {0, cfg_offset}.
//      Full-precision, no saturation (the range fits outWidth).
//  - Remaining-element counter decrements on each output handshake.
//  - out_last = out_valid && remaining==1.
//  - A final partial word emits only the remaining elements; its unused upper fields are discarded.
//  - busy = (state != IDLE).
// STRUCTURE
//  - Shared package quant_pkg holds:
//      the state typedef (IDLE/FETCH/EMIT/DONE);
//      the legal-width constants;
//      function elems_per_word(bits).
//  - Sub-module zp_extend is combinational: elem, bits, unsigned, offset -> out_data.
//    It is reused by the array input path.
//  - The top level holds the FSM, the shift buffer, the per-word index and the remaining counter.
// TESTING
//  1. bits=8, signed, offset=0, n=4, word 0x80FF017F
//       -> 127, 1, -1, -128; out_last on the 4th element; done 1 cycle later.
//  2. bits=4, unsigned, offset=8, n=10, words 0x76543210 then 0x000000BA
//       -> -8..-1, then 2, 3; second word accepted in the same cycle as the 8th handshake.
//  3. bits=2, signed, offset=0, n=4, word 0x000000E4 -> 0, 1, -2, -1.
//  4. Case 2 with out_ready random at 50%
//       -> identical sequence, no drops or duplicates, out_data stable while stalled.
//  5. start with n=0 -> done=1 on the next cycle; out_valid and in_ready never assert.
//  6. nrst=1 during EMIT of case 1 after 2 outputs
//       -> next cycle all outputs are 0 and busy=0; a fresh start replays case 1 correctly.

Source files
------------

// File: rtl/quant_pkg.sv
// Shared definitions for the activation quantisation path.
// Holds the transfer FSM state type, datapath widths, the legal element
// widths and helpers that map an element width to its legalised value and
// to the number of elements packed into one word.
package quant_pkg;

  localparam int unsigned WORD_WIDTH       = 32;
  localparam int unsigned MAX_OUTPUT_WIDTH = 8;
  localparam int unsigned OUT_WIDTH        = MAX_OUTPUT_WIDTH + 2;
  localparam int unsigned COUNT_BITS       = 16;

  localparam logic [3:0] BITS_1 = 4'd1;
  localparam logic [3:0] BITS_2 = 4'd2;
  localparam logic [3:0] BITS_4 = 4'd4;
  localparam logic [3:0] BITS_8 = 4'd8;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    EMIT,
    DONE
  } state_t;

  // Any width other than 1/2/4 behaves as 8.
  function automatic logic [3:0] legal_bits(input logic [3:0] bits);
    case (bits)
      BITS_1, BITS_2, BITS_4: return bits;
      default:                return BITS_8;
    endcase
  endfunction

  function automatic logic [5:0] elems_per_word(input logic [3:0] bits);
    case (legal_bits(bits))
      BITS_1:  return 6'd32;
      BITS_2:  return 6'd16;
      BITS_4:  return 6'd8;
      default: return 6'd4;
    endcase
  endfunction

endpackage

// File: rtl/activation_unpacker_if.sv
// Stream bundle between the activation buffer, the unpacker and the array
// input driver.
//   in_word/in_valid/in_ready     : packed-word stream into the unpacker
//   out_data/out_valid/out_ready  : signed element stream out of the unpacker
//   out_last                      : marks the final element of a transfer
// master = environment side, slave = unpacker side.
interface activation_unpacker_if;
  import quant_pkg::*;

  logic [WORD_WIDTH-1:0]       in_word;
  logic                        in_valid;
  logic                        in_ready;
  logic signed [OUT_WIDTH-1:0] out_data;
  logic                        out_valid;
  logic                        out_ready;
  logic                        out_last;

  modport master (
    output in_word, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );

  modport slave (
    input  in_word, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last
  );

endinterface

// File: rtl/zp_extend.sv
// Combinational element extender with zero-point removal.
//   elem          : low-aligned packed element (only the low `bits` used)
//   bits          : element width, illegal values behave as 8
//   elem_unsigned : 1 = zero-extend, 0 = sign-extend
//   offset        : unsigned zero-point subtracted from the extended element
//   out_data      : full-precision signed result (-383..255 fits)
module zp_extend
  import quant_pkg::*;
(
  input  logic [MAX_OUTPUT_WIDTH-1:0] elem,
  input  logic [3:0]                  bits,
  input  logic                        elem_unsigned,
  input  logic [MAX_OUTPUT_WIDTH-1:0] offset,
  output logic signed [OUT_WIDTH-1:0] out_data
);

  logic                 sgn;
  logic [OUT_WIDTH-1:0] ext;

  always_comb begin
    sgn = 1'b0;
    ext = '0;
    case (legal_bits(bits))
      BITS_1: begin
        sgn = ~elem_unsigned & elem[0];
        ext = {{(OUT_WIDTH-1){sgn}}, elem[0]};
      end
      BITS_2: begin
        sgn = ~elem_unsigned & elem[1];
        ext = {{(OUT_WIDTH-2){sgn}}, elem[1:0]};
      end
      BITS_4: begin
        sgn = ~elem_unsigned & elem[3];
        ext = {{(OUT_WIDTH-4){sgn}}, elem[3:0]};
      end
      default: begin
        sgn = ~elem_unsigned & elem[7];
        ext = {{(OUT_WIDTH-8){sgn}}, elem[7:0]};
      end
    endcase
    out_data = $signed(ext - {{(OUT_WIDTH-MAX_OUTPUT_WIDTH){1'b0}}, offset});
  end

endmodule

// File: rtl/activation_unpacker.sv
// Unpacks 32-bit words of LSB-first packed activations into one signed,
// zero-point-corrected element per cycle.
//   clk, nrst       : clock, synchronous active-high reset
//   start           : pulse in IDLE latches cfg_* and begins a transfer
//   cfg_output_bits : element width 1/2/4/8 (others act as 8)
//   cfg_unsigned    : zero-extend (1) or sign-extend (0)
//   cfg_offset      : zero-point subtracted from each element
//   cfg_num_elems   : element count of the transfer
//   bus (slave)     : word input stream and element output stream
//   busy            : transfer in progress
//   done            : one-cycle pulse after the final element handshake
module activation_unpacker
  import quant_pkg::*;
(
  input  logic                        clk,
  input  logic                        nrst,
  input  logic                        start,
  input  logic [3:0]                  cfg_output_bits,
  input  logic                        cfg_unsigned,
  input  logic [MAX_OUTPUT_WIDTH-1:0] cfg_offset,
  input  logic [COUNT_BITS-1:0]       cfg_num_elems,
  activation_unpacker_if.slave        bus,
  output logic                        busy,
  output logic                        done
);

  state_t                      state, next_state;
  logic [3:0]                  bits_r;
  logic                        uns_r;
  logic [MAX_OUTPUT_WIDTH-1:0] off_r;
  logic [COUNT_BITS-1:0]       remaining;
  logic [WORD_WIDTH-1:0]       buf_r;
  logic [4:0]                  idx;
  logic signed [OUT_WIDTH-1:0] out_data_r;
  logic signed [OUT_WIDTH-1:0] zp_out;
  logic [MAX_OUTPUT_WIDTH-1:0] elem_src;
  logic                        in_ready;
  logic                        handshake;
  logic                        accept;
  logic                        word_last;
  logic                        final_elem;

  assign word_last  = ({1'b0, idx} == elems_per_word(bits_r) - 6'd1);
  assign final_elem = (remaining == COUNT_BITS'(1));
  assign handshake  = (state == EMIT) && bus.out_ready;
  assign accept     = bus.in_valid && in_ready;

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    case (state)
      IDLE:  if (start) next_state = (cfg_num_elems == '0) ? DONE : FETCH;
      FETCH: begin
        in_ready = 1'b1;
        if (bus.in_valid) next_state = EMIT;
      end
      EMIT: begin
        if (bus.out_ready) begin
          if (final_elem) begin
            next_state = DONE;
          end else if (word_last) begin
            // Next word may be taken in the same cycle as this handshake.
            in_ready = 1'b1;
            if (!bus.in_valid) next_state = FETCH;
          end
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // A freshly accepted word is presented directly; otherwise the buffer
  // already holds the next undisplayed element in its low bits.
  assign elem_src = accept ? bus.in_word[MAX_OUTPUT_WIDTH-1:0] : buf_r[MAX_OUTPUT_WIDTH-1:0];

  zp_extend u_zp_extend (
    .elem          (elem_src),
    .bits          (bits_r),
    .elem_unsigned (uns_r),
    .offset        (off_r),
    .out_data      (zp_out)
  );

  always_ff @(posedge clk) begin
    if (nrst) begin
      state      <= IDLE;
      bits_r     <= BITS_8;
      uns_r      <= 1'b0;
      off_r      <= '0;
      remaining  <= '0;
      buf_r      <= '0;
      idx        <= '0;
      out_data_r <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && start) begin
        bits_r    <= legal_bits(cfg_output_bits);
        uns_r     <= cfg_unsigned;
        off_r     <= cfg_offset;
        remaining <= cfg_num_elems;
      end
      if (accept) begin
        out_data_r <= zp_out;
        buf_r      <= bus.in_word >> bits_r;
        idx        <= '0;
      end else if (handshake && !word_last && !final_elem) begin
        out_data_r <= zp_out;
        buf_r      <= buf_r >> bits_r;
        idx        <= idx + 5'd1;
      end
      if (handshake) remaining <= remaining - COUNT_BITS'(1);
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_data  = out_data_r;
  assign bus.out_valid = (state == EMIT);
  assign bus.out_last  = (state == EMIT) && final_elem;
  assign busy          = (state != IDLE);
  assign done          = (state == DONE);

endmodule

// File: tb/tb_activation_unpacker.sv
module tb_activation_unpacker;
  import quant_pkg::*;

  typedef struct {
    int data;
    bit last;
  } exp_t;

  logic                        clk = 1'b0;
  logic                        nrst;
  logic                        start;
  logic [3:0]                  cfg_output_bits;
  logic                        cfg_unsigned;
  logic [MAX_OUTPUT_WIDTH-1:0] cfg_offset;
  logic [COUNT_BITS-1:0]       cfg_num_elems;
  logic                        busy;
  logic                        done;

  activation_unpacker_if bus ();

  activation_unpacker dut (
    .clk             (clk),
    .nrst            (nrst),
    .start           (start),
    .cfg_output_bits (cfg_output_bits),
    .cfg_unsigned    (cfg_unsigned),
    .cfg_offset      (cfg_offset),
    .cfg_num_elems   (cfg_num_elems),
    .bus             (bus),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   pop_cnt  = 0;
  bit   rnd_mode = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int d, input bit l);
    exp_t e;
    e.data = d;
    e.last = l;
    exp_q.push_back(e);
  endtask

  // Monitor: pops the scoreboard on every output handshake, checks the
  // stall hold and the done pulse following the final element.
  initial begin : monitor
    exp_t e;
    bit   stall_prev   = 1'b0;
    int   stall_data   = 0;
    bit   stall_last   = 1'b0;
    bit   done_pending = 1'b0;
    forever begin
      @(negedge clk);
      if (stall_prev) begin
        check("stall_valid", int'(bus.out_valid), 1);
        check("stall_data", int'($signed(bus.out_data)), stall_data);
        check("stall_last", int'(bus.out_last), int'(stall_last));
      end
      if (done_pending) begin
        check("done_pulse", int'(done), 1);
        done_pending = 1'b0;
      end
      if (bus.out_valid && bus.out_ready && !nrst) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", int'($signed(bus.out_data)), -9999);
        end else begin
          e = exp_q.pop_front();
          check("out_data", int'($signed(bus.out_data)), e.data);
          check("out_last", int'(bus.out_last), int'(e.last));
          if (e.last) done_pending = 1'b1;
        end
        pop_cnt++;
      end
      stall_prev = bus.out_valid && !bus.out_ready && !nrst;
      stall_data = int'($signed(bus.out_data));
      stall_last = bus.out_last;
    end
  end

  initial begin : ready_gen
    forever begin
      @(posedge clk);
      #1;
      if (rnd_mode) bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic do_start(input logic [3:0] b, input logic u, input logic [7:0] off,
                          input logic [15:0] n);
    @(posedge clk);
    #1;
    cfg_output_bits = b;
    cfg_unsigned    = u;
    cfg_offset      = off;
    cfg_num_elems   = n;
    start           = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_start", int'(busy), 1);
  endtask

  task automatic send_word(input logic [31:0] w, input bit overlap);
    int t = 0;
    bus.in_word  = w;
    bus.in_valid = 1'b1;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.in_ready && t < 300);
    if (!bus.in_ready) begin
      check("in_ready_timeout", 0, 1);
      bus.in_valid = 1'b0;
      return;
    end
    if (overlap) check("b2b_accept", int'(bus.out_valid && bus.out_ready), 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("latency_valid", int'(bus.out_valid), 1);
  endtask

  task automatic wait_done();
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!done && t < 400);
    if (!done) check("done_timeout", 0, 1);
    check("queue_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
    check("idle_busy", int'(busy), 0);
  endtask

  task automatic case1_push();
    push_exp(127, 0);
    push_exp(1, 0);
    push_exp(-1, 0);
    push_exp(-128, 1);
  endtask

  task automatic case2_push();
    for (int i = 0; i < 8; i++) push_exp(i - 8, 0);
    push_exp(2, 0);
    push_exp(3, 1);
  endtask

  initial begin : main
    int base;
    int t;
    nrst            = 1'b1;
    start           = 1'b0;
    cfg_output_bits = '0;
    cfg_unsigned    = 1'b0;
    cfg_offset      = '0;
    cfg_num_elems   = '0;
    bus.in_word     = '0;
    bus.in_valid    = 1'b0;
    bus.out_ready   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", int'(bus.in_ready), 0);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_last", int'(bus.out_last), 0);
    check("rst_out_data", int'($signed(bus.out_data)), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    nrst = 1'b0;

    // Case 1: 8-bit signed
    case1_push();
    do_start(4'd8, 1'b0, 8'd0, 16'd4);
    send_word(32'h80FF017F, 1'b0);
    wait_done();

    // Case 2: 4-bit unsigned, offset 8, two words back to back
    case2_push();
    do_start(4'd4, 1'b1, 8'd8, 16'd10);
    send_word(32'h76543210, 1'b0);
    send_word(32'h000000BA, 1'b1);
    wait_done();

    // Case 3: 2-bit signed
    push_exp(0, 0);
    push_exp(1, 0);
    push_exp(-2, 0);
    push_exp(-1, 1);
    do_start(4'd2, 1'b0, 8'd0, 16'd4);
    send_word(32'h000000E4, 1'b0);
    wait_done();

    // Case 4: case 2 under random backpressure
    rnd_mode = 1'b1;
    case2_push();
    do_start(4'd4, 1'b1, 8'd8, 16'd10);
    send_word(32'h76543210, 1'b0);
    send_word(32'h000000BA, 1'b0);
    wait_done();
    rnd_mode      = 1'b0;
    bus.out_ready = 1'b1;

    // Case 5: empty transfer
    do_start(4'd8, 1'b0, 8'd0, 16'd0);
    check("n0_done", int'(done), 1);
    check("n0_in_ready", int'(bus.in_ready), 0);
    check("n0_out_valid", int'(bus.out_valid), 0);
    @(posedge clk);
    #1;
    check("n0_done_clear", int'(done), 0);
    check("n0_busy_clear", int'(busy), 0);
    check("n0_out_valid2", int'(bus.out_valid), 0);

    // Case 7: illegal width acts as 8, maximal offset
    push_exp(-255, 0);
    push_exp(0, 1);
    do_start(4'd3, 1'b1, 8'd255, 16'd2);
    send_word(32'h0000FF00, 1'b0);
    wait_done();

    // Case 8: 1-bit signed, partial word
    push_exp(-1, 0);
    push_exp(0, 0);
    push_exp(-1, 1);
    do_start(4'd1, 1'b0, 8'd0, 16'd3);
    send_word(32'hFFFFFFF5, 1'b0);
    wait_done();

    // Case 6: reset mid-EMIT after two outputs, then replay case 1
    case1_push();
    base = pop_cnt;
    do_start(4'd8, 1'b0, 8'd0, 16'd4);
    send_word(32'h80FF017F, 1'b0);
    t = 0;
    while (pop_cnt < base + 2 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("rst_mid_pops", pop_cnt - base, 2);
    @(posedge clk);
    #1;
    nrst          = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_out_valid", int'(bus.out_valid), 0);
    check("mid_rst_out_last", int'(bus.out_last), 0);
    check("mid_rst_in_ready", int'(bus.in_ready), 0);
    check("mid_rst_out_data", int'($signed(bus.out_data)), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_done", int'(done), 0);
    exp_q.delete();
    nrst          = 1'b0;
    bus.out_ready = 1'b1;
    case1_push();
    do_start(4'd8, 1'b0, 8'd0, 16'd4);
    send_word(32'h80FF017F, 1'b0);
    wait_done();

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
